// File: rtl/load_store_unit.sv
// load_store_unit: CPU load/store initiator driving a word-addressed req/ready memory port
module load_store_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        write_q, write_d, uns_q, uns_d, err_q, err_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, word_q, word_d, rdata_q, rdata_d;
    logic [31:0] sh, mask, ext, merged;
    logic        bad, expired;
    assign req_ready  = (state_q == IDLE) & !rst;
    assign resp_valid = state_q == RESP;
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign mem_req    = (state_q == RD) | (state_q == WR);
    assign mem_we     = state_q == WR;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = word_q;
    assign bad        = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) | (req_size == 2'b10 & req_addr[1:0] != 2'b00);
    assign expired    = cnt_q == 8'(TIMEOUT - 1);
    // lane extraction/extension for loads and byte-lane merge for read-modify-write stores
    always_comb begin
        sh     = mem_rdata >> {addr_q[1:0], 3'b000};
        ext    = size_q == 2'b00 ? {{24{!uns_q & sh[7]}}, sh[7:0]} :
                 size_q == 2'b01 ? {{16{!uns_q & sh[15]}}, sh[15:0]} : mem_rdata;
        mask   = (size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << {addr_q[1:0], 3'b000};
        merged = (mem_rdata & ~mask) | ((wdata_q << {addr_q[1:0], 3'b000}) & mask);
    end
    // next-state logic: accept, memory phases with timeout, one-cycle response
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                write_d = req_write;
                size_d  = req_size;
                uns_d   = req_unsigned;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                word_d  = req_wdata;
                cnt_d   = '0;
                rdata_d = '0;
                err_d   = bad;
                state_d = bad ? RESP : (req_write & req_size == 2'b10) ? WR : RD;
            end
            RD: if (mem_ready) begin
                cnt_d   = '0;
                word_d  = write_q ? merged : word_q;
                rdata_d = write_q ? '0 : ext;
                state_d = write_q ? WR : RESP;
            end else if (expired) begin
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            WR: if (mem_ready) begin
                state_d = RESP;
            end else if (expired) begin
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and latched request registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random load/store transactions against a byte-lane memory model
module tb_load_store_unit;
    localparam int TO = 15;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_write = 0, req_unsigned = 0, mem_ready = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
    logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    int          vectors = 0, miscompares = 0;
    bit [31:0]   mem [bit [29:0]];
    logic [31:0] last_wdata, obs_rd;
    logic        obs_err;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] load_val(bit [31:0] wv, bit [1:0] sz, bit u, bit [1:0] off);
        longint v;
        if (sz == 2) return wv;
        if (sz == 0) begin
            v = (wv >> (8 * off)) % 256;
            if (!u && v >= 128) v -= 256;
        end else begin
            v = (wv >> (16 * off[1])) % 65536;
            if (!u && v >= 32768) v -= 65536;
        end
        return v[31:0];
    endfunction

    function automatic bit [31:0] merge(bit [31:0] wv, bit [1:0] sz, bit [1:0] off, bit [31:0] wd);
        bit [7:0] b[4];
        for (int i = 0; i < 4; i++) b[i] = wv[8*i +: 8];
        for (int i = 0; i < (sz == 0 ? 1 : 2); i++) b[off + i] = wd[8*i +: 8];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    // one memory phase: dly low-ready cycles then ready, or abort after TO low cycles
    task automatic phase(input bit we, input bit [31:0] a, input int dly, input bit [31:0] wexp, output bit to);
        to = 0;
        for (int c = 0; c < TO; c++) begin
            chk("mem_req", mem_req, 1);
            chk("mem_we", mem_we, we);
            chk("mem_addr", mem_addr, {a[31:2], 2'b00});
            chk("busy_resp_valid", resp_valid, 0);
            chk("busy_req_ready", req_ready, 0);
            if (we) begin
                chk("mem_wdata", mem_wdata, wexp);
                last_wdata = mem_wdata;
            end
            mem_ready = (c == dly);
            mem_rdata = (c == dly) ? mem[a[31:2]] : $urandom;
            @(posedge clk);
            @(negedge clk);
            mem_ready = 0;
            if (c == dly) return;
        end
        to = 1;
    endtask

    task automatic txn(input bit w, input bit [1:0] sz, input bit u, input bit [31:0] a,
                       input bit [31:0] wd, input int dly);
        bit bad, to;
        bit [29:0] wi;
        bit [31:0] exp, wr;
        wi = a[31:2];
        bad = sz == 3 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0);
        if (!mem.exists(wi)) mem[wi] = $urandom;
        exp = 0;
        to = 0;
        chk("req_ready", req_ready, 1);
        req_valid = 1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        mem_ready = $urandom;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0; req_write = $urandom; req_size = $urandom; req_unsigned = $urandom;
        req_addr = $urandom; req_wdata = $urandom;
        if (!bad && !(w && sz == 2)) phase(0, a, dly, 0, to);
        if (!bad && !to) begin
            if (!w) exp = load_val(mem[wi], sz, u, a[1:0]);
            else begin
                wr = (sz == 2) ? wd : merge(mem[wi], sz, a[1:0], wd);
                phase(1, a, dly, wr, to);
                if (!to) mem[wi] = wr;
            end
        end
        chk("resp_valid", resp_valid, 1);
        chk("resp_err", resp_err, bad | to);
        chk("resp_rdata", resp_rdata, exp);
        chk("resp_mem_req", mem_req, 0);
        chk("resp_req_ready", req_ready, 0);
        obs_rd = resp_rdata;
        obs_err = resp_err;
        mem_ready = $urandom;
        @(posedge clk);
        @(negedge clk);
        mem_ready = 0;
        chk("idle_resp_valid", resp_valid, 0);
        chk("idle_mem_req", mem_req, 0);
    endtask

    initial begin
        int r, dly;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 0;
        @(negedge clk);

        mem[4] = 32'hDEAD_BEEF;
        txn(0, 2, 0, 32'h10, 0, 0);
        chk("ld_word", obs_rd, 32'hDEAD_BEEF);
        mem[4] = 32'h80FF_1234;
        txn(0, 0, 0, 32'h13, 0, 0);
        chk("ld_byte_s", obs_rd, 32'hFFFF_FF80);
        txn(0, 0, 1, 32'h13, 0, 1);
        chk("ld_byte_u", obs_rd, 32'h0000_0080);
        txn(0, 1, 0, 32'h12, 0, 2);
        chk("ld_half_s", obs_rd, 32'hFFFF_80FF);
        mem[8] = 32'h1122_3344;
        txn(1, 0, 0, 32'h21, 32'hAB, 0);
        chk("sb_wdata", last_wdata, 32'h1122_AB44);
        chk("sb_err", obs_err, 0);
        txn(0, 2, 0, 32'h06, 0, 0);
        chk("misaligned_err", obs_err, 1);
        txn(0, 3, 0, 32'h00, 0, 0);
        chk("size11_err", obs_err, 1);
        chk("size11_rdata", obs_rd, 0);
        txn(0, 2, 0, 32'h30, 0, 100);
        chk("timeout_err", obs_err, 1);
        txn(0, 2, 0, 32'h30, 0, TO - 1);
        chk("late_ready_err", obs_err, 0);
        txn(1, 1, 0, 32'h32, 32'h5A5A, 100);
        chk("rmw_timeout_err", obs_err, 1);

        req_valid = 1; req_write = 1; req_size = 2; req_addr = 32'h40; req_wdata = 32'h1234_5678;
        mem_ready = 0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        chk("wr_mem_we", mem_we, 1);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_mem_req", mem_req, 0);
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_req_ready_rst", req_ready, 0);
        rst = 0;
        #1;
        chk("abort_req_ready", req_ready, 1);
        @(negedge clk);
        chk("abort_no_resp", resp_valid, 0);
        mem[16] = 32'hCAFE_F00D;
        txn(0, 2, 0, 32'h40, 0, 1);
        chk("after_rst_ld", obs_rd, 32'hCAFE_F00D);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            dly = r < 7 ? r % 3 : r == 7 ? TO - 1 : r == 8 ? TO : TO + 5;
            txn($urandom, $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2)),
                $urandom, 32'($urandom_range(0, 63)), $urandom, dly);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port.
- Takes one byte, halfword or word load/store request per transaction from the CPU datapath and drives a word-addressed memory with a req/ready handshake.
- Extracts and extends loaded sub-words; performs read-modify-write for sub-word stores.
- Flags misaligned accesses, illegal sizes and memory timeouts.

Parameters:
- TIMEOUT, 15, max cycles to wait for mem_ready in one memory phase before aborting with error (1..255).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data; sub-word data in low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: misaligned, illegal size or timeout
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable, valid with mem_req
- mem_addr  out  32  word address; req_addr with bits [1:0] forced to 0
- mem_wdata  out  32  full-word write data
- mem_ready  in  1  memory completes the current phase this cycle
- mem_rdata  in  32  read word, sampled when mem_req & !mem_we & mem_ready

Behaviour:
- Reset (rst high at a clock edge):
  - State becomes IDLE; timeout counter and all latched request fields are cleared.
  - resp_valid, resp_err, mem_req, mem_we are 0; resp_rdata, mem_addr, mem_wdata are 0.
  - req_ready = (state==IDLE) & !rst.
  - Reset mid-transaction aborts it: no response, mem_req drops the next cycle.
- States:
  - IDLE: req_ready=1. On req_valid at an edge, latch write, size, unsigned, addr and wdata, then branch:
    - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size 11 -> RESP with err=1. No memory access.
    - Load -> RD.
    - Word store -> WR.
    - Byte/half store -> RD (read phase of RMW).
  - RD: mem_req=1, mem_we=0, held stable until mem_ready. On mem_ready, capture mem_rdata.
    - Load -> RESP.
    - Store -> merge new bytes into the captured word -> WR.
  - WR: mem_req=1, mem_we=1, mem_wdata = full word (merged word for sub-word stores), held until mem_ready -> RESP.
  - RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err, then IDLE. req_ready=0 in this state.
- Byte lanes are little-endian:
  - Byte lane = addr[1:0]; bits [8*lane+7 : 8*lane].
  - Half lane = addr[1]; bits [16*addr[1]+15 : 16*addr[1]].
- Load extension: sign bit is the top bit of the selected lane unless req_unsigned=1. req_unsigned is ignored for word loads.
- Timeout:
  - Counter clears on entering RD or WR and increments each cycle mem_ready is low there.
  - If it reaches TIMEOUT, drop mem_req, go to RESP with err=1 and rdata=0.
  - An RMW timing out in RD issues no write.
  - mem_ready high on the same cycle the counter reaches TIMEOUT: mem_ready wins.
- mem_ready outside RD/WR is ignored.
- Latency counted from the accept edge: error response on next cycle. Aligned load or word store with mem_ready immediate → resp_valid on 2nd cycle; RMW store → 3rd cycle.
- No back-to-back acceptance: the next request is accepted at the earliest on the cycle after RESP.

Test Plan:
- Word load, addr 0x0000_0010, mem_rdata 0xDEAD_BEEF, mem_ready on first RD cycle -> mem_addr 0x10, mem_we 0; resp_valid 2 cycles after accept, rdata 0xDEADBEEF, err 0.
- Byte load addr 0x13, mem_rdata 0x80FF_1234, signed -> rdata 0xFFFF_FF80; repeat unsigned -> 0x0000_0080. Halfword signed at 0x12 -> 0xFFFF_80FF.
- Byte store 0xAB to addr 0x21, memory word 0x1122_3344 -> RD then WR at mem_addr 0x20, mem_wdata 0x1122_AB44, mem_we=1 only in WR, resp err 0.
- Misaligned word load at 0x06, and size 11 at 0x00 -> mem_req never asserted, resp_valid next cycle with err 1, rdata 0.
- mem_ready held low, TIMEOUT=15 -> mem_req high 15 cycles then low, resp err 1. Variant: mem_ready at cycle 15 -> normal completion.
- rst asserted while in WR with mem_ready low -> next cycle mem_req 0, req_ready 1, no resp_valid. A new load afterwards completes normally.
